count_event_mon: RTL and testbench

- Downstream consumer of a free-running or host-stepped 8-bit counter value.
- Converts value changes into single-cycle event pulses, formatted for okTriggerOut endpoints.
- Keeps sticky event flags, a saturating match counter and a capture register, formatted for okWireOut readback.
- Runs entirely in the counter's clock domain; the trigger endpoint handles the crossing to ti_clk.

---
 rtl/count_event_mon_if.sv | 25 ++
 rtl/count_event_mon.sv | 110 +++++++++++
 tb/tb_count_event_mon.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/count_event_mon_if.sv
// Bus between a counter-watching monitor and its host-side endpoints.
// The master drives the observed value, threshold and clear; the slave returns events and readback.
interface count_event_mon_if #(
    parameter int WIDTH = 8,
    parameter int HITW  = 16
);
    logic [WIDTH-1:0] count_in;
    logic [WIDTH-1:0] cmp_val;
    logic             clear;
    logic [3:0]       ev_trig;
    logic [3:0]       ev_sticky;
    logic [HITW-1:0]  hit_count;
    logic [WIDTH-1:0] snapshot;
    logic             dir_up;

    modport master (
        output count_in, cmp_val, clear,
        input  ev_trig, ev_sticky, hit_count, snapshot, dir_up
    );

    modport slave (
        input  count_in, cmp_val, clear,
        output ev_trig, ev_sticky, hit_count, snapshot, dir_up
    );
endinterface

// File: rtl/count_event_mon.sv
// Turns changes of an observed counter into one-cycle event pulses plus sticky flags, hit counter and wrap snapshot.
// Define COUNT_EVENT_MON_SNAPSHOT_EN to implement the snapshot register; otherwise snapshot reads 0.
module count_event_mon #(
    parameter int WIDTH = 8,
    parameter int HITW  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    count_event_mon_if.slave  mon
);
    localparam int EV_ZERO  = 0;
    localparam int EV_MATCH = 1;
    localparam int EV_WUP   = 2;
    localparam int EV_WDN   = 3;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [HITW-1:0]  HIT_MAX  = '1;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prev;
    logic             primed;

    logic [3:0]       ev_trig_q;
    logic [3:0]       ev_sticky_q;
    logic [HITW-1:0]  hit_q;
    logic             dir_q;

    logic             changed;
    logic             step_up;
    logic             step_down;
    logic [3:0]       ev_next;
    logic [HITW-1:0]  hit_base;
    logic [HITW-1:0]  hit_next;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        changed   = primed && (cur != prev);
        ev_next   = '0;
        step_up   = 1'b0;
        step_down = 1'b0;
        hit_base  = mon.clear ? '0 : hit_q;
        hit_next  = hit_base;

        if (changed) begin
            ev_next[EV_ZERO]  = (cur == '0);
            ev_next[EV_MATCH] = (cur == mon.cmp_val);
            ev_next[EV_WUP]   = (prev == ALL_ONES) && (cur == '0);
            ev_next[EV_WDN]   = (prev == '0) && (cur == ALL_ONES);
            step_up           = (cur == prev + ONE);
            step_down         = (cur == prev - ONE);
        end

        // A match in the clear cycle counts on top of the cleared value.
        if (ev_next[EV_MATCH] && (hit_base != HIT_MAX)) begin
            hit_next = hit_base + HITW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur         <= '0;
            prev        <= '0;
            primed      <= 1'b0;
            ev_trig_q   <= '0;
            ev_sticky_q <= '0;
            hit_q       <= '0;
            dir_q       <= 1'b0;
        end else begin
            cur         <= mon.count_in;
            // The first sample seeds both stages so it is never compared against the reset value.
            prev        <= primed ? cur : mon.count_in;
            primed      <= 1'b1;
            ev_trig_q   <= ev_next;
            ev_sticky_q <= (mon.clear ? 4'b0000 : ev_sticky_q) | ev_next;
            hit_q       <= hit_next;
            if (step_up) begin
                dir_q <= 1'b1;
            end else if (step_down) begin
                dir_q <= 1'b0;
            end
        end
    end

    assign mon.ev_trig   = ev_trig_q;
    assign mon.ev_sticky = ev_sticky_q;
    assign mon.hit_count = hit_q;
    assign mon.dir_up    = dir_q;

`ifdef COUNT_EVENT_MON_SNAPSHOT_EN
    logic [WIDTH-1:0] snap_q;

    // A wrap load takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_q <= '0;
        end else if (ev_next[EV_WUP] || ev_next[EV_WDN]) begin
            snap_q <= cur;
        end else if (mon.clear) begin
            snap_q <= '0;
        end
    end

    assign mon.snapshot = snap_q;
`else
    assign mon.snapshot = '0;
`endif

endmodule

// File: tb/tb_count_event_mon.sv
// Self-checking bench for count_event_mon: directed vector table, hit saturation sequence, random run against a model.
// Counter width is reduced (HITW=12) so saturation is reachable in a short run.
module tb_count_event_mon;
    localparam int WIDTH   = 8;
    localparam int TB_HITW = 12;
    localparam logic [TB_HITW-1:0] HIT_MAX = '1;

    logic clk;
    logic reset_n;

    count_event_mon_if #(.WIDTH(WIDTH), .HITW(TB_HITW)) bus ();

    count_event_mon #(.WIDTH(WIDTH), .HITW(TB_HITW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mon     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: keeps the last two accepted samples since reset and applies the event rules directly.
    logic [7:0]         hist[$];
    logic [3:0]         m_ev;
    logic [3:0]         m_st;
    logic [TB_HITW-1:0] m_hit;
    logic               m_dir;
    logic [7:0]         m_snap;

    task automatic model_edge(input logic r, input logic [7:0] c, input logic [7:0] k, input logic cl);
        logic [7:0] n, o, d;
        logic [3:0] ev;
        if (!r) begin
            hist.delete();
            m_ev = '0; m_st = '0; m_hit = '0; m_dir = 1'b0; m_snap = '0;
        end else begin
            ev = '0;
            if (hist.size() == 2 && hist[1] != hist[0]) begin
                n = hist[1];
                o = hist[0];
                ev[0] = (n == 8'h00);
                ev[1] = (n == k);
                ev[2] = (o == 8'hFF) && (n == 8'h00);
                ev[3] = (o == 8'h00) && (n == 8'hFF);
                d = n - o;
                if (d == 8'h01) m_dir = 1'b1;
                else if (d == 8'hFF) m_dir = 1'b0;
`ifdef COUNT_EVENT_MON_SNAPSHOT_EN
                if (ev[2] || ev[3]) m_snap = n;
`endif
            end
            if (cl && !(ev[2] || ev[3])) m_snap = '0;
            m_st = (cl ? 4'b0000 : m_st) | ev;
            if (cl) m_hit = '0;
            if (ev[1] && m_hit != HIT_MAX) m_hit = m_hit + 1'b1;
            m_ev = ev;
            hist.push_back(c);
            if (hist.size() > 2) void'(hist.pop_front());
        end
    endtask

    task automatic step(input logic r, input logic [7:0] c, input logic [7:0] k, input logic cl);
        reset_n      = r;
        bus.count_in = c;
        bus.cmp_val  = k;
        bus.clear    = cl;
        @(posedge clk);
        model_edge(r, c, k, cl);
        #1;
    endtask

    typedef struct {
        logic       rst_n;
        logic [7:0] cnt;
        logic [7:0] cmp;
        logic       clr;
        logic [3:0] ev;
        logic [3:0] st;
        logic [15:0] hit;
        logic       dir;
        logic [7:0] snap;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [7:0] c, input logic [7:0] k, input logic cl,
                                input logic [3:0] ev, input logic [3:0] st, input logic [15:0] hit,
                                input logic dir, input logic [7:0] snap);
        vec_t v;
        v.rst_n = r; v.cnt = c; v.cmp = k; v.clr = cl;
        v.ev = ev; v.st = st; v.hit = hit; v.dir = dir;
`ifdef COUNT_EVENT_MON_SNAPSHOT_EN
        v.snap = snap;
`else
        v.snap = 8'h00;
`endif
        return v;
    endfunction

    vec_t tbl[35];
    logic [7:0] last_cnt;
    logic [7:0] cmp_r;
    logic [7:0] c_r;

    initial begin
        reset_n = 1'b0;
        bus.count_in = '0;
        bus.cmp_val  = '0;
        bus.clear    = 1'b0;
        m_ev = '0; m_st = '0; m_hit = '0; m_dir = 1'b0; m_snap = '0;

        // Outputs in each row are those visible just after that row's clock edge.
        tbl[0] = mk(0, 8'h00, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        for (int i = 1; i <= 10; i++) tbl[i] = mk(1, 8'h00, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        tbl[11] = mk(1, 8'h7E, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        tbl[12] = mk(1, 8'h7F, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        tbl[13] = mk(1, 8'h80, 8'h80, 0, 4'h0, 4'h0, 16'd0, 1, 8'h00);
        tbl[14] = mk(1, 8'h80, 8'h80, 0, 4'h2, 4'h2, 16'd1, 1, 8'h00);
        tbl[15] = mk(1, 8'h81, 8'h80, 0, 4'h0, 4'h2, 16'd1, 1, 8'h00);
        tbl[16] = mk(1, 8'h81, 8'h80, 0, 4'h0, 4'h2, 16'd1, 1, 8'h00);
        tbl[17] = mk(1, 8'hFE, 8'h00, 1, 4'h0, 4'h0, 16'd0, 1, 8'h00);
        tbl[18] = mk(1, 8'hFF, 8'h00, 0, 4'h0, 4'h0, 16'd0, 1, 8'h00);
        tbl[19] = mk(1, 8'h00, 8'h00, 0, 4'h0, 4'h0, 16'd0, 1, 8'h00);
        tbl[20] = mk(1, 8'h00, 8'h00, 0, 4'h7, 4'h7, 16'd1, 1, 8'h00);
        tbl[21] = mk(1, 8'hFF, 8'h00, 0, 4'h0, 4'h7, 16'd1, 1, 8'h00);
        tbl[22] = mk(1, 8'hFF, 8'h00, 0, 4'h8, 4'hF, 16'd1, 0, 8'hFF);
        tbl[23] = mk(1, 8'h37, 8'h80, 0, 4'h0, 4'hF, 16'd1, 0, 8'hFF);
        tbl[24] = mk(1, 8'h00, 8'h80, 0, 4'h0, 4'hF, 16'd1, 0, 8'hFF);
        tbl[25] = mk(1, 8'h00, 8'h80, 0, 4'h1, 4'hF, 16'd1, 0, 8'hFF);
        tbl[26] = mk(0, 8'h00, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        tbl[27] = mk(1, 8'hFF, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        tbl[28] = mk(1, 8'hFF, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        tbl[29] = mk(1, 8'hFF, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        tbl[30] = mk(1, 8'h00, 8'h80, 0, 4'h0, 4'h0, 16'd0, 0, 8'h00);
        tbl[31] = mk(1, 8'h00, 8'h80, 0, 4'h5, 4'h5, 16'd0, 1, 8'h00);
        tbl[32] = mk(1, 8'hFF, 8'h80, 1, 4'h0, 4'h0, 16'd0, 1, 8'h00);
        tbl[33] = mk(1, 8'hFF, 8'h80, 1, 4'h8, 4'h8, 16'd0, 0, 8'hFF);
        tbl[34] = mk(1, 8'hFF, 8'h80, 0, 4'h0, 4'h8, 16'd0, 0, 8'hFF);

        for (int i = 0; i < 35; i++) begin
            step(tbl[i].rst_n, tbl[i].cnt, tbl[i].cmp, tbl[i].clr);
            check($sformatf("row%0d ev_trig", i),   32'(bus.ev_trig),   32'(tbl[i].ev));
            check($sformatf("row%0d ev_sticky", i), 32'(bus.ev_sticky), 32'(tbl[i].st));
            check($sformatf("row%0d hit_count", i), 32'(bus.hit_count), 32'(tbl[i].hit));
            check($sformatf("row%0d dir_up", i),    32'(bus.dir_up),    32'(tbl[i].dir));
            check($sformatf("row%0d snapshot", i),  32'(bus.snapshot),  32'(tbl[i].snap));
        end

        // Saturation: alternating 0x80/0x81 gives one match every two cycles.
        for (int i = 0; i < 8200; i++) step(1, (i % 2 == 1) ? 8'h81 : 8'h80, 8'h80, 0);
        step(1, 8'h80, 8'h80, 0);
        check("sat hit_count", 32'(bus.hit_count), 32'(HIT_MAX));
        check("sat ev_sticky", 32'(bus.ev_sticky), 32'h0000000A);
        // Clear lands on the edge where the next 0x80 match registers.
        step(1, 8'h81, 8'h80, 1);
        check("clr+match hit_count", 32'(bus.hit_count), 32'h00000001);
        check("clr+match ev_sticky", 32'(bus.ev_sticky), 32'h00000002);
        check("clr+match ev_trig",   32'(bus.ev_trig),   32'h00000002);

        // Randomized run against the model, biased toward boundary values.
        last_cnt = 8'h81;
        cmp_r    = 8'h80;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) cmp_r = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       c_r = 8'h00;
                1:       c_r = 8'hFF;
                2:       c_r = last_cnt + 8'h01;
                3:       c_r = last_cnt - 8'h01;
                4:       c_r = cmp_r;
                5:       c_r = last_cnt;
                default: c_r = 8'($urandom);
            endcase
            last_cnt = c_r;
            step(($urandom_range(0, 63) != 0), c_r, cmp_r, ($urandom_range(0, 15) == 0));
            check("rnd ev_trig",   32'(bus.ev_trig),   32'(m_ev));
            check("rnd ev_sticky", 32'(bus.ev_sticky), 32'(m_st));
            check("rnd hit_count", 32'(bus.hit_count), 32'(m_hit));
            check("rnd dir_up",    32'(bus.dir_up),    32'(m_dir));
            check("rnd snapshot",  32'(bus.snapshot),  32'(m_snap));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
